// File: rtl/timer_prescaler.sv
// Count-enable prescaler for the 64-bit APB timer: power-of-two or linear (N+1) divide,
// with a shadowed divider setting that is applied only at a period boundary or while idle.
module timer_prescaler #(
  parameter int CNT_W = 8,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             timer_en,
  input  logic             div_en,
  input  logic             halt,
  input  logic             clr,
  input  logic             div_mode,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_upd,
  output logic [CNT_W-1:0] cnt,
  output logic             tick,
  output logic             cfg_pending
);

  logic             timer_en_q;
  logic             sh_mode;
  logic             act_mode;
  logic [CNT_W-1:0] sh_val;
  logic [CNT_W-1:0] act_val;

  logic             te_fall;
  logic             nxt_mode;
  logic [CNT_W-1:0] nxt_val;
  logic [DIV_W-1:0] exp_sel;
  logic [CNT_W-1:0] tc;

  assign te_fall = timer_en_q & ~timer_en;

  // A strobe in the same cycle as an apply point bypasses the shadow, so it is not lost.
  assign nxt_mode = div_upd ? div_mode : sh_mode;
  assign nxt_val  = div_upd ? div_val  : sh_val;

  // Terminal count from the active configuration only.
  always_comb begin
    // NOTE: give every combinational output a default on entry so no path leaves it unassigned (no latch).
    tc      = '0;
    exp_sel = act_val[DIV_W-1:0];
    if (act_mode) begin
      tc = act_val;
    end else if (int'(exp_sel) >= CNT_W) begin
      tc = '1;
    end else begin
      tc = (CNT_W'(1) << exp_sel) - CNT_W'(1);
    end
  end

  // While nothing is pending the shadow equals the active config, so applying
  // nxt_* at every apply point is harmless and keeps the branches uniform.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_en_q  <= 1'b0;
      sh_mode     <= 1'b0;
      sh_val      <= '0;
      act_mode    <= 1'b0;
      act_val     <= '0;
      cnt         <= '0;
      tick        <= 1'b0;
      cfg_pending <= 1'b0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
      timer_en_q <= timer_en;
      if (div_upd) begin
        sh_mode <= div_mode;
        sh_val  <= div_val;
      end

      if (clr || te_fall) begin
        cnt         <= '0;
        tick        <= 1'b0;
        act_mode    <= nxt_mode;
        act_val     <= nxt_val;
        cfg_pending <= 1'b0;
      end else if (timer_en && halt) begin
        tick <= 1'b0;
        if (div_upd) cfg_pending <= 1'b1;
      end else if (!timer_en) begin
        cnt         <= '0;
        tick        <= 1'b0;
        act_mode    <= nxt_mode;
        act_val     <= nxt_val;
        cfg_pending <= 1'b0;
      end else if (!div_en) begin
        cnt         <= '0;
        tick        <= 1'b1;
        act_mode    <= nxt_mode;
        act_val     <= nxt_val;
        cfg_pending <= 1'b0;
      end else if (cnt == tc) begin
        cnt         <= '0;
        tick        <= 1'b1;
        act_mode    <= nxt_mode;
        act_val     <= nxt_val;
        cfg_pending <= 1'b0;
      end else begin
        cnt  <= cnt + CNT_W'(1);
        tick <= 1'b0;
        if (div_upd) cfg_pending <= 1'b1;
      end
    end
  end

endmodule
